// File: rtl/uart_instr_loader.sv
// UART program loader: frames of 0xA5, 16-bit word count, big-endian words and XOR checksum into imem.
// Optional build macro LOADER_OPCODE_CHECK_EN rejects words whose opcode is outside the supported MIPS subset.
module uart_instr_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic              bad_opcode
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [7:0]  START_BYTE = 8'hA5;

    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK} state_t;

    state_t          state;
    logic [7:0]      len_hi;
    logic [15:0]     n_words;
    logic [ADDR_W:0] widx;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_sr;
    logic [7:0]      chk_acc;
    logic [TO_W-1:0] idle_cnt;

    logic        accept;
    logic        timeout_hit;
    logic        last_word;
    logic [16:0] len_full;
    logic        word_ok;
    logic        bad_seen;

    assign rx_ready    = 1'b1;
    assign accept      = rx_valid;
    // Expiry takes priority over any byte presented in the same cycle.
    assign timeout_hit = (state != S_IDLE) && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign len_full    = {1'b0, len_hi, rx_data};
    assign last_word   = (17'(widx) + 17'd1) == {1'b0, n_words};

`ifdef LOADER_OPCODE_CHECK_EN
    function automatic logic opcode_ok(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b001000,
            6'b000100, 6'b000101, 6'b000010, 6'b000011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign word_ok  = opcode_ok(word_sr[23:18]);
    assign bad_seen = bad_opcode;
`else
    assign word_ok    = 1'b1;
    assign bad_seen   = 1'b0;
    assign bad_opcode = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_hi     <= '0;
            n_words    <= '0;
            widx       <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
            chk_acc    <= '0;
            idle_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef LOADER_OPCODE_CHECK_EN
            bad_opcode <= 1'b0;
`endif
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;

            if (state == S_IDLE || accept || timeout_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (timeout_hit) begin
                state      <= S_IDLE;
                load_error <= 1'b1;
                cpu_hold   <= 1'b0;
            end else if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == START_BYTE) begin
                            state      <= S_LEN_HI;
                            cpu_hold   <= 1'b1;
                            load_error <= 1'b0;
                            widx       <= '0;
                            byte_cnt   <= '0;
                            chk_acc    <= '0;
`ifdef LOADER_OPCODE_CHECK_EN
                            bad_opcode <= 1'b0;
`endif
                        end
                    end
                    S_LEN_HI: begin
                        len_hi <= rx_data;
                        state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        n_words <= len_full[15:0];
                        if (len_full == 17'd0) begin
                            state <= S_CHK;
                        end else if (len_full > MAX_WORDS) begin
                            state      <= S_IDLE;
                            load_error <= 1'b1;
                            cpu_hold   <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        chk_acc  <= chk_acc ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt != 2'd3) begin
                            word_sr <= {word_sr[15:0], rx_data};
                        end else begin
                            // Rejected words still consume an address so later words land where the image expects.
                            if (word_ok) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= widx[ADDR_W-1:0];
                                imem_wdata <= {word_sr, rx_data};
                            end
`ifdef LOADER_OPCODE_CHECK_EN
                            if (!word_ok)
                                bad_opcode <= 1'b1;
`endif
                            widx <= widx + 1'b1;
                            if (last_word)
                                state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                        if (rx_data == chk_acc && !bad_seen)
                            load_done <= 1'b1;
                        else
                            load_error <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader (ADDR_W=4, short timeout); define LOADER_OPCODE_CHECK_EN to test opcode rejection.
module tb_uart_instr_loader;

    localparam int ADDR_W = 4;
    localparam int TO     = 40;

    logic              clk;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic              bad_opcode;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wr0;
    int dn0;
    logic [31:0] shadow [0:(2**ADDR_W)-1];

    uart_instr_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .bad_opcode (bad_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write and done pulse shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (imem_we) begin
            shadow[imem_addr] = imem_wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (load_done)
            done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 2**ADDR_W; i++) shadow[i] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);

        check("rst_rx_ready",   {31'd0, rx_ready},   32'd1);
        check("rst_imem_we",    {31'd0, imem_we},    32'd0);
        check("rst_imem_addr",  {28'd0, imem_addr},  32'd0);
        check("rst_imem_wdata", imem_wdata,          32'd0);
        check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd0);
        check("rst_load_done",  {31'd0, load_done},  32'd0);
        check("rst_load_error", {31'd0, load_error}, 32'd0);
        check("rst_bad_opcode", {31'd0, bad_opcode}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Two-word frame, checksum 20^08^00^05^01^09^50^20 = 0x55
        wr0 = wr_cnt; dn0 = done_cnt;
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        check("t1_hold_mid", {31'd0, cpu_hold}, 32'd1);
        send(8'h01); send(8'h09); send(8'h50); send(8'h20);
        send(8'h55);
        check("t1_done_pulse", {31'd0, load_done}, 32'd1);
        check("t1_hold_rel",   {31'd0, cpu_hold},  32'd0);
        idle(1);
        check("t1_done_1cyc",  {31'd0, load_done}, 32'd0);
        check("t1_addr0",      shadow[0],          32'h2008_0005);
        check("t1_addr1",      shadow[1],          32'h0109_5020);
        check("t1_writes",     wr_cnt - wr0,       32'd2);
        check("t1_error",      {31'd0, load_error}, 32'd0);

        // Same frame, bad checksum
        wr0 = wr_cnt; dn0 = done_cnt;
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        send(8'h01); send(8'h09); send(8'h50); send(8'h20);
        send(8'h00);
        check("t2_error",  {31'd0, load_error}, 32'd1);
        check("t2_hold",   {31'd0, cpu_hold},   32'd0);
        idle(2);
        check("t2_writes", wr_cnt - wr0,   32'd2);
        check("t2_nodone", done_cnt - dn0, 32'd0);

        // Length 17 exceeds 16-word memory
        wr0 = wr_cnt;
        send(8'hA5); send(8'h00); send(8'h11);
        check("t3_error",  {31'd0, load_error}, 32'd1);
        check("t3_hold",   {31'd0, cpu_hold},   32'd0);
        idle(2);
        check("t3_nowrite", wr_cnt - wr0, 32'd0);

        // Exactly full memory: words 0x0000000i, XOR of 0..15 = 0
        wr0 = wr_cnt; dn0 = done_cnt;
        send(8'hA5); send(8'h00); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            send(8'h00); send(8'h00); send(8'h00); send(8'(i));
        end
        send(8'h00);
        idle(2);
        check("t3b_writes", wr_cnt - wr0,   32'd16);
        check("t3b_done",   done_cnt - dn0, 32'd1);
        check("t3b_addr15", shadow[15],     32'h0000_000F);
        check("t3b_addr7",  shadow[7],      32'h0000_0007);
        check("t3b_error",  {31'd0, load_error}, 32'd0);

        // Timeout mid-word
        send(8'hA5); send(8'h00); send(8'h01); send(8'h20); send(8'h08);
        idle(TO - 1);
        check("t4_pre_error", {31'd0, load_error}, 32'd0);
        check("t4_pre_hold",  {31'd0, cpu_hold},   32'd1);
        idle(1);
        check("t4_error", {31'd0, load_error}, 32'd1);
        check("t4_hold",  {31'd0, cpu_hold},   32'd0);
        idle(2);
        send(8'hA5);
        check("t4_clear", {31'd0, load_error}, 32'd0);
        check("t4_rehold", {31'd0, cpu_hold},  32'd1);
        send(8'h00); send(8'h00); send(8'h00);
        check("t4_done", {31'd0, load_done}, 32'd1);
        idle(2);

        // Start byte arriving on the expiry cycle is discarded
        send(8'hA5); send(8'h00); send(8'h01); send(8'h20);
        idle(TO - 1);
        send(8'hA5);
        check("t4r_error", {31'd0, load_error}, 32'd1);
        check("t4r_hold",  {31'd0, cpu_hold},   32'd0);
        idle(2);

        // Junk before start, empty frame
        wr0 = wr_cnt; dn0 = done_cnt;
        send(8'h00); send(8'h11);
        check("t5_junk_hold", {31'd0, cpu_hold}, 32'd0);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        check("t5_done",  {31'd0, load_done},  32'd1);
        check("t5_error", {31'd0, load_error}, 32'd0);
        idle(2);
        check("t5_nowrite", wr_cnt - wr0, 32'd0);

        // Opcode 0x3F word with correct checksum 0xFC
        wr0 = wr_cnt; dn0 = done_cnt;
        send(8'hA5); send(8'h00); send(8'h01);
        send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
        send(8'hFC);
        idle(2);
`ifdef LOADER_OPCODE_CHECK_EN
        check("t6_nowrite", wr_cnt - wr0,        32'd0);
        check("t6_bad",     {31'd0, bad_opcode}, 32'd1);
        check("t6_error",   {31'd0, load_error}, 32'd1);
        check("t6_nodone",  done_cnt - dn0,      32'd0);
`else
        check("t6_write",  wr_cnt - wr0,        32'd1);
        check("t6_word",   shadow[0],           32'hFC00_0000);
        check("t6_bad",    {31'd0, bad_opcode}, 32'd0);
        check("t6_done",   done_cnt - dn0,      32'd1);
`endif
        check("t6_hold", {31'd0, cpu_hold}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
